// File: rtl/seg_scan_mux.sv
// Multi-digit 7-segment scanner with frame-synchronous shadow commit; SEG_LZ_BLANK_EN enables leading-zero blanking.
// Registered outputs (1 cycle after counter state); load-to-display <= NUM_DIGITS*SLOT_CYCLES+1 cycles; no backpressure, last load wins.
module seg_scan_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int SLOT_CYCLES    = 100000,
    parameter int GUARD_CYCLES   = 2,
    parameter int AN_ACTIVE_HIGH = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          load,
    output logic                          pending,
    output logic [3:0]                    bcd_out,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_HIGH != 0) ? {NUM_DIGITS{1'b0}} : {NUM_DIGITS{1'b1}};
    localparam logic AN_ON = (AN_ACTIVE_HIGH != 0);

    typedef enum logic {S_GUARD = 1'b0, S_ON = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d, buf_val_q, buf_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, buf_dp_q, buf_dp_d;
    logic                    pending_q, pending_d;
    logic [3:0]              bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    dp_q, dp_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic                    frame_tick_q, frame_tick_d;
    logic                    commit;
    logic [NUM_DIGITS-1:0]   blank;

    // Counters describe the position whose outputs are registered on this edge.
    always_comb begin
        slot_cnt_d = slot_cnt_q + CNT_W'(1);
        scan_idx_d = scan_idx_q;
        if (slot_cnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
            slot_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
        end
        commit = (slot_cnt_q == '0) && (scan_idx_q == '0);
    end

    // Shadow only moves at the frame boundary; a load on that same edge bypasses the buffer.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        buf_val_d    = buf_val_q;
        buf_dp_d     = buf_dp_q;
        pending_d    = pending_q;
        if (commit) begin
            if (load) begin
                shadow_val_d = value;
                shadow_dp_d  = dp_in;
                pending_d    = 1'b0;
            end else if (pending_q) begin
                shadow_val_d = buf_val_q;
                shadow_dp_d  = buf_dp_q;
                pending_d    = 1'b0;
            end
        end else if (load) begin
            buf_val_d = value;
            buf_dp_d  = dp_in;
            pending_d = 1'b1;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    always_comb begin : lz_blank
        logic seen;
        seen  = 1'b0;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if ((shadow_val_d[4*i +: 4] != 4'd0) || shadow_dp_d[i]) begin
                seen = 1'b1;
            end
            blank[i] = !seen;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_GUARD: if (int'(slot_cnt_q) >= GUARD_CYCLES) state_d = S_ON;
            S_ON:    if ((slot_cnt_q == '0) && (GUARD_CYCLES > 0)) state_d = S_GUARD;
            default: state_d = S_GUARD;
        endcase
    end

    always_comb begin
        an_d         = AN_OFF;
        dp_d         = 1'b0;
        bcd_d        = 4'd0;
        digit_idx_d  = scan_idx_q;
        frame_tick_d = commit;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                bcd_d = shadow_val_d[4*i +: 4];
                if ((state_d == S_ON) && !blank[i]) begin
                    an_d[i] = AN_ON;
                    dp_d    = shadow_dp_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_GUARD;
            slot_cnt_q   <= '0;
            scan_idx_q   <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            buf_val_q    <= '0;
            buf_dp_q     <= '0;
            pending_q    <= 1'b0;
            bcd_q        <= 4'd0;
            an_q         <= AN_OFF;
            dp_q         <= 1'b0;
            digit_idx_q  <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_cnt_q   <= slot_cnt_d;
            scan_idx_q   <= scan_idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            buf_val_q    <= buf_val_d;
            buf_dp_q     <= buf_dp_d;
            pending_q    <= pending_d;
            bcd_q        <= bcd_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            digit_idx_q  <= digit_idx_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pending    = pending_q;
    assign bcd_out    = bcd_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign digit_idx  = digit_idx_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: position-based reference model checked every cycle, plus pinned literal expectations.
module tb_seg_scan_mux;
    localparam int N = 4;
    localparam int S = 8;
    localparam int G = 2;
    localparam int FRAME = N * S;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic          load = 1'b0;
    logic          pending;
    logic [3:0]    bcd_out;
    logic [3:0]    an;
    logic          dp;
    logic [1:0]    digit_idx;
    logic          frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    seg_scan_mux #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .GUARD_CYCLES(G), .AN_ACTIVE_HIGH(0)) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
        .pending(pending), .bcd_out(bcd_out), .an(an), .dp(dp),
        .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Model: k = clock edges since reset release; output after edge k shows scan position k-1.
    int          k = 0;
    logic [15:0] m_val = '0, m_bval = '0;
    logic [3:0]  m_dp = '0, m_bdp = '0;
    bit          m_pend = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k = 0; m_val = '0; m_dp = '0; m_bval = '0; m_bdp = '0; m_pend = 0;
        end else begin
            if (k % FRAME == 0) begin
                if (load) begin
                    m_val = value; m_dp = dp_in; m_pend = 0;
                end else if (m_pend) begin
                    m_val = m_bval; m_dp = m_bdp; m_pend = 0;
                end
            end else if (load) begin
                m_bval = value; m_bdp = dp_in; m_pend = 1;
            end
            k = k + 1;
        end
    end

    function automatic bit m_blank(input int i);
`ifdef SEG_LZ_BLANK_EN
        if (i == 0) return 0;
        return ((m_val >> (4 * i)) == 16'd0) && ((m_dp >> i) == 4'd0);
`else
        return (i < 0);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, k=%0d)", name, act, exp, $time, k);
        end
    endtask

    always @(negedge clk) begin
        int p, slot, cnt;
        logic [3:0] e_an, e_bcd;
        logic e_dp, e_ft;
        if (k == 0) begin
            e_an = 4'hF; e_bcd = 4'h0; e_dp = 0; e_ft = 0; slot = 0;
        end else begin
            p    = k - 1;
            slot = (p / S) % N;
            cnt  = p % S;
            e_ft = (p % FRAME == 0);
            e_bcd = 4'((m_val >> (4 * slot)) & 16'hF);
            if (cnt >= G && !m_blank(slot)) e_an = ~(4'b0001 << slot);
            else                            e_an = 4'hF;
            e_dp = (cnt >= G) ? m_dp[slot] : 1'b0;
        end
        check("model_an", an, e_an);
        check("model_bcd", bcd_out, e_bcd);
        check("model_dp", dp, e_dp);
        check("model_frame_tick", frame_tick, e_ft);
        check("model_digit_idx", digit_idx, slot);
        check("model_pending", pending, m_pend);
    end

    task automatic go_to(input int target);
        int budget = 0;
        while (k < target && budget < 500) begin
            @(posedge clk); #1;
            budget++;
        end
        if (k < target) begin
            n_checks++; n_fail++;
            $display("FAIL go_to timeout: k=%0d, required %0d", k, target);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    initial begin
        #12;
        check("reset_an", an, 4'hF);
        check("reset_ft", frame_tick, 1'b0);
        check("reset_pending", pending, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Free-running scan with no load
        go_to(1);  @(negedge clk);
        check("lit_ft_first", frame_tick, 1'b1);
        check("lit_an_guard0", an, 4'b1111);
        go_to(3);  @(negedge clk);
        check("lit_an_dig0", an, 4'b1110);
        go_to(9);  @(negedge clk);
        check("lit_an_guard1", an, 4'b1111);
        check("lit_idx1", digit_idx, 2'd1);
        go_to(11); @(negedge clk);
        check("lit_an_dig1", an, 4'b1101);
        go_to(33); @(negedge clk);
        check("lit_ft_period", frame_tick, 1'b1);

        // Mid-frame load waits for the frame boundary
        go_to(40); pulse_load(16'h1234, 4'h0);
        @(negedge clk);
        check("lit_pending_set", pending, 1'b1);
        check("lit_bcd_unchanged", bcd_out, 4'h0);
        go_to(65); @(negedge clk);
        check("lit_pending_clr", pending, 1'b0);
        check("lit_bcd_d0", bcd_out, 4'h4);
        go_to(73); @(negedge clk); check("lit_bcd_d1", bcd_out, 4'h3);
        go_to(81); @(negedge clk); check("lit_bcd_d2", bcd_out, 4'h2);
        go_to(89); @(negedge clk); check("lit_bcd_d3", bcd_out, 4'h1);

        // Last load in a frame wins
        go_to(70); pulse_load(16'h1111, 4'h0);
        go_to(80); pulse_load(16'h5678, 4'h0);
        go_to(97);  @(negedge clk); check("lit_last_wins_d0", bcd_out, 4'h8);
        go_to(105); @(negedge clk); check("lit_last_wins_d1", bcd_out, 4'h7);

        // Load on the commit edge bypasses the pending buffer
        go_to(128); pulse_load(16'h0042, 4'h0);
        @(negedge clk);
        check("lit_bypass_pending", pending, 1'b0);
        check("lit_bypass_bcd", bcd_out, 4'h2);
        go_to(147); @(negedge clk);
`ifdef SEG_LZ_BLANK_EN
        check("lit_blank_d2", an, 4'b1111);
`else
        check("lit_lit_d2", an, 4'b1011);
`endif
        go_to(160); pulse_load(16'h0042, 4'b0100);
        go_to(179); @(negedge clk);
        check("lit_dp_d2_an", an, 4'b1011);
        check("lit_dp_d2_dp", dp, 1'b1);
        go_to(187); @(negedge clk);
`ifdef SEG_LZ_BLANK_EN
        check("lit_blank_d3", an, 4'b1111);
`else
        check("lit_lit_d3", an, 4'b0111);
`endif

        // Asynchronous reset in slot 2 with a load pending
        go_to(210); pulse_load(16'h9876, 4'h0);
        @(negedge clk);
        check("lit_pending_before_rst", pending, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("lit_async_an", an, 4'hF);
        check("lit_async_pending", pending, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        go_to(1); @(negedge clk);
        check("lit_restart_ft", frame_tick, 1'b1);
        check("lit_restart_idx", digit_idx, 2'd0);
        go_to(33); @(negedge clk);
        check("lit_discarded", bcd_out, 4'h0);

        // Randomized loads with occasional asynchronous resets
        @(posedge clk); #1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                logic [15:0] v;
                for (int d = 0; d < 4; d++)
                    v[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
                value = v;
                dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 999) == 0) begin
                #($urandom_range(1, 8));
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                load  = 1'b0;
            end
            @(posedge clk); #1;
        end
        load = 1'b0;
        @(posedge clk); @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
